axi4_rd_slave_mem: RTL and testbench
====================================

Name: axi4_rd_slave_mem

Overview:
Synthesizable AXI4 read-only slave with word-addressed internal memory. It is the downstream target for the team's AXI4 master read stimulus: it accepts AR requests and returns R bursts.
A backdoor write port preloads memory contents from the bench or a loader.
Intended for sim benches and early bring-up in place of a real memory controller.

Parameters:
DATA_WIDTH, 32, R data width in bits; power of 2, minimum 32
ADDR_WIDTH, 32, AR address width
ID_WIDTH, 12, AR/R ID width
MEM_AW, 10, log2 of memory depth in words (default 1024 words)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous reset, active-high
s_axi_araddr_in  in  ADDR_WIDTH  read start byte address
s_axi_arburst_in  in  2  burst type
s_axi_arid_in  in  ID_WIDTH  transaction ID
s_axi_arlen_in  in  8  beats minus 1
s_axi_arsize_in  in  3  log2 bytes per beat
s_axi_arvalid_in  in  1  AR valid
s_axi_arready_out  out  1  AR ready
s_axi_rdata_out  out  DATA_WIDTH  read data
s_axi_rid_out  out  ID_WIDTH  echoed ID
s_axi_rlast_out  out  1  final beat of burst
s_axi_rresp_out  out  2  response code
s_axi_rvalid_out  out  1  R valid
s_axi_rready_in  in  1  R ready
mem_wr_en_in  in  1  backdoor write strobe
mem_wr_addr_in  in  MEM_AW  backdoor word index
mem_wr_data_in  in  DATA_WIDTH  backdoor write data

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset: state=IDLE; arready=0, rvalid=0, rlast=0, rdata=0, rid=0, rresp=0.
  - arready rises on the first clk_in edge after rst_in deasserts.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst immediately. No further R beats.
- IDLE state:
  - arready=1, rvalid=0.
  - On arvalid&&arready, latch id, len, size, burst and addr.
  - Register rdata=mem[idx(addr)] and set rvalid=1 on the next cycle (AR-accept to first beat = 1 cycle). Go to BURST.
  - arready=0 from the cycle after accept.
- BURST state:
  - arready=0; one outstanding transaction only.
  - rdata, rid, rresp and rlast stay stable while rvalid&&!rready.
  - On each rvalid&&rready, the beat counter increments and rdata loads mem[idx(next_addr)] in the same edge. This gives back-to-back beats at full rate.
  - rlast=1 when beat counter == len.
  - Handshake on the last beat: rvalid=0, rlast=0, go to IDLE, arready=1 on the following cycle.
  - Minimum gap between bursts is 1 idle cycle.
- Address generation, beat step = 1<<size:
  - FIXED (00): address is held.
  - INCR (01): addr+step.
  - WRAP (10): wrap boundary = (len+1)*step, aligned down. When addr+step reaches the boundary top, addr returns to the boundary base. WRAP with len not in {1,3,7,15} behaves as INCR.
  - Reserved (11): address held; rresp=SLVERR for every beat.
- Size rule: size > log2(DATA_WIDTH/8) gives rresp=SLVERR for every beat and rdata=0. Otherwise rresp=OKAY.
- Index rule: idx = ((addr-BASE_ADDR) >> log2(DATA_WIDTH/8)) truncated to MEM_AW bits.
  - Narrow beats return the full word; the master selects lanes.
  - 4KB boundary crossing is not checked.
- Backdoor write: mem[mem_wr_addr_in] = mem_wr_data_in at the clk_in edge.
  - If a write hits the same word as the rdata load in that cycle, the load takes the old data (read-before-write).
  - Backdoor writes are accepted in every state, including during reset.
- rid = latched arid for all beats of the burst.

Optional Feature:
Macro AXI4_SLV_RANGE_CHK_EN.
- Defined: any beat whose (addr-BASE_ADDR) is negative or ≥ 2^MEM_AW words returns rresp=SLVERR (2'b10) with rdata=0, evaluated per beat. In-range beats of the same burst return OKAY.
- Undefined: the index truncates modulo depth and rresp follows the size/burst rules only.

Decomposition:
- Package axi4_pkg holds:
  - Burst codes: BURST_FIXED, BURST_INCR, BURST_WRAP.
  - Response codes: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Read FSM state encoding: IDLE, BURST.
- One combinational sub-module is natural: axi4_burst_addr_gen (inputs addr, size, len, burst; output next_addr).
  - The team's future write slave reuses it.

Test Plan:
1. Preload mem[0..15]=i*16'h1111, BASE_ADDR=0; AR addr=0x0, INCR, len=3, size=2, id=12'h5A5, rready=1 -> 4 beats on consecutive cycles: 0x0, 0x1111, 0x2222, 0x3333. rlast on beat 4, rid=0x5A5, rresp=0, arready back to 1 one cycle after the last beat.
2. WRAP len=3 size=2 addr=0x8 -> data from words 2,3,0,1. FIXED len=2 addr=0x4 -> word 1 three times.
3. INCR len=7, rready toggled 1,0,0,1,... -> rdata/rlast held during stalls. All 8 beats delivered in order, no duplicate or lost beats.
4. size=3 (DATA_WIDTH=32), len=1 -> 2 beats with rresp=2'b10, rdata=0. Burst=11 -> all beats SLVERR.
5. Assert rst_in for 1 cycle during beat 2 of a len=7 burst -> rvalid=0 the next cycle. arready=1 one cycle after rst_in drops. A new AR completes correctly.
6. With AXI4_SLV_RANGE_CHK_EN, MEM_AW=4: INCR len=3 from word 14 -> beats 1-2 OKAY with data, beats 3-4 SLVERR with rdata=0. Without the macro -> beats 3-4 return words 0 and 1 with OKAY.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the slave models: burst and response codes,
// read FSM state encoding and the WRAP length decoder.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  // log2(len+1) for the legal WRAP lengths; 0 marks a length that degrades to INCR
  function automatic logic [2:0] wrap_shift(input logic [7:0] len);
    case (len)
      8'd1:    return 3'd1;
      8'd3:    return 3'd2;
      8'd7:    return 3'd3;
      8'd15:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for AXI4 FIXED/INCR/WRAP bursts.
// Shared between the read slave and the planned write slave.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [2:0]            wsh;

  always_comb begin
    step        = ADDR_WIDTH'(1) << size_i;
    incr_addr   = addr_i + step;
    wsh         = wrap_shift(len_i);
    wrap_mask   = (step << wsh) - ADDR_WIDTH'(1);
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = incr_addr;
      BURST_WRAP: begin
        // Keep the container base, let only the in-container offset advance
        if (wsh == 3'd0) next_addr_o = incr_addr;
        else             next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      end
      default: next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi4_rd_slave_mem.sv
// AXI4 read-only slave backed by a word-addressed memory with a backdoor preload port.
// Optional per-beat address range checking is enabled by AXI4_SLV_RANGE_CHK_EN.
module axi4_rd_slave_mem
  import axi4_pkg::*;
#(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   ID_WIDTH   = 12,
  parameter int                   MEM_AW     = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr_in,
  input  logic [1:0]            s_axi_arburst_in,
  input  logic [ID_WIDTH-1:0]   s_axi_arid_in,
  input  logic [7:0]            s_axi_arlen_in,
  input  logic [2:0]            s_axi_arsize_in,
  input  logic                  s_axi_arvalid_in,
  output logic                  s_axi_arready_out,
  output logic [DATA_WIDTH-1:0] s_axi_rdata_out,
  output logic [ID_WIDTH-1:0]   s_axi_rid_out,
  output logic                  s_axi_rlast_out,
  output logic [1:0]            s_axi_rresp_out,
  output logic                  s_axi_rvalid_out,
  input  logic                  s_axi_rready_in,
  input  logic                  mem_wr_en_in,
  input  logic [MEM_AW-1:0]     mem_wr_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_wr_data_in
);

  localparam int BYTE_LG = $clog2(DATA_WIDTH / 8);
  localparam int DEPTH   = 1 << MEM_AW;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  rd_state_e             state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;

  logic                  ar_hs;
  logic                  r_hs;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [2:0]            beat_size;
  logic [1:0]            beat_burst;
  logic                  beat_err;
  logic                  beat_zero;
  logic [DATA_WIDTH-1:0] beat_data;

  function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
    return MEM_AW'((a - BASE_ADDR) >> BYTE_LG);
  endfunction

`ifdef AXI4_SLV_RANGE_CHK_EN
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> (BYTE_LG + MEM_AW)) != '0);
  endfunction
`endif

  assign ar_hs = (state_q == IDLE) && arready_q && s_axi_arvalid_in;
  assign r_hs  = rvalid_q && s_axi_rready_in;

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Beat about to be loaded: first beat comes straight from AR, later beats from the generator
  always_comb begin
    if (state_q == IDLE) begin
      beat_addr  = s_axi_araddr_in;
      beat_size  = s_axi_arsize_in;
      beat_burst = s_axi_arburst_in;
    end else begin
      beat_addr  = next_addr;
      beat_size  = size_q;
      beat_burst = burst_q;
    end
    beat_zero = (beat_size > 3'(BYTE_LG));
    beat_err  = beat_zero || (beat_burst == BURST_RSVD);
`ifdef AXI4_SLV_RANGE_CHK_EN
    if (out_of_range(beat_addr)) begin
      beat_zero = 1'b1;
      beat_err  = 1'b1;
    end
`endif
    beat_data = beat_zero ? '0 : mem_q[mem_idx(beat_addr)];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = BURST;
      BURST:   if (r_hs && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (s_axi_arlen_in == 8'd0);
          rdata_d   = beat_data;
          rresp_d   = beat_err ? RESP_SLVERR : RESP_OKAY;
          id_d      = s_axi_arid_in;
          addr_d    = s_axi_araddr_in;
          len_d     = s_axi_arlen_in;
          size_d    = s_axi_arsize_in;
          burst_d   = s_axi_arburst_in;
          beat_d    = 8'd0;
        end
      end
      BURST: begin
        arready_d = 1'b0;
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            rlast_d = ((beat_q + 8'd1) == len_q);
            rdata_d = beat_data;
            rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      default: arready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      id_q      <= '0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      id_q      <= id_d;
    end
  end

  // Burst bookkeeping is only meaningful while rvalid is high, so it carries no reset
  always_ff @(posedge clk_in) begin
    addr_q  <= addr_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
    beat_q  <= beat_d;
  end

  // Same-edge read of this word above sees the pre-write contents
  always_ff @(posedge clk_in) begin
    if (mem_wr_en_in) mem_q[mem_wr_addr_in] <= mem_wr_data_in;
  end

  assign s_axi_arready_out = arready_q;
  assign s_axi_rvalid_out  = rvalid_q;
  assign s_axi_rlast_out   = rlast_q;
  assign s_axi_rdata_out   = rdata_q;
  assign s_axi_rresp_out   = rresp_q;
  assign s_axi_rid_out     = id_q;

endmodule

// File: tb/tb_axi4_rd_slave_mem.sv
// Directed bench for axi4_rd_slave_mem with a 16-word memory (MEM_AW=4).
// Expectations for the range-check scenario follow AXI4_SLV_RANGE_CHK_EN.
module tb_axi4_rd_slave_mem;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IW  = 12;
  localparam int MAW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] araddr;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic          rlast;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          wr_en;
  logic [MAW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  axi4_rd_slave_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (IW),
    .MEM_AW     (MAW),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .s_axi_araddr_in   (araddr),
    .s_axi_arburst_in  (arburst),
    .s_axi_arid_in     (arid),
    .s_axi_arlen_in    (arlen),
    .s_axi_arsize_in   (arsize),
    .s_axi_arvalid_in  (arvalid),
    .s_axi_arready_out (arready),
    .s_axi_rdata_out   (rdata),
    .s_axi_rid_out     (rid),
    .s_axi_rlast_out   (rlast),
    .s_axi_rresp_out   (rresp),
    .s_axi_rvalid_out  (rvalid),
    .s_axi_rready_in   (rready),
    .mem_wr_en_in      (wr_en),
    .mem_wr_addr_in    (wr_addr),
    .mem_wr_data_in    (wr_data)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] bd [16];
  logic [1:0]    br [16];
  logic          bl [16];
  logic [IW-1:0] bi [16];
  logic [DW-1:0] ed [16];
  logic [1:0]    er [16];
  int            nbeats;
  int            ncyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_ar(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [IW-1:0] id);
    int w;
    araddr  = a;
    arlen   = len;
    arsize  = sz;
    arburst = bt;
    arid    = id;
    arvalid = 1'b1;
    w = 0;
    while (!arready && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) check("ar_timeout", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    wr_en   = 1'b0;
  endtask

  // mode 0: rready always high; mode 1: rready high every third cycle
  task automatic collect(input int len, input int mode);
    int cyc;
    nbeats = 0;
    cyc    = 0;
    while (nbeats <= len && cyc < 200) begin
      rready = (mode == 0) || (cyc % 3 == 0);
      if (rvalid && rready) begin
        bd[nbeats] = rdata;
        br[nbeats] = rresp;
        bl[nbeats] = rlast;
        bi[nbeats] = rid;
        nbeats++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    ncyc   = cyc;
    check("beat_count", 64'(nbeats), 64'(len + 1));
  endtask

  task automatic check_beats(input string name, input int len, input logic [IW-1:0] id, input logic chk_data);
    for (int i = 0; i <= len; i++) begin
      if (chk_data) check($sformatf("%s_data%0d", name, i), 64'(bd[i]), 64'(ed[i]));
      check($sformatf("%s_resp%0d", name, i), 64'(br[i]), 64'(er[i]));
      check($sformatf("%s_last%0d", name, i), 64'(bl[i]), 64'(i == len));
      check($sformatf("%s_id%0d", name, i), 64'(bi[i]), 64'(id));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    araddr  = '0;
    arburst = 2'b01;
    arid    = '0;
    arlen   = '0;
    arsize  = 3'd2;
    arvalid = 1'b0;
    rready  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Preload through the backdoor while reset is held
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = MAW'(i);
      wr_data = DW'(i) * 32'h1111;
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_rid", 64'(rid), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    rst = 1'b0;
    tick();
    check("arready_after_rst", 64'(arready), 64'd1);

    // INCR len=3 at full rate
    issue_ar(32'h0, 8'd3, 3'd2, 2'b01, 12'h5A5);
    collect(3, 0);
    for (int i = 0; i < 4; i++) begin ed[i] = DW'(i) * 32'h1111; er[i] = 2'b00; end
    check_beats("incr", 3, 12'h5A5, 1'b1);
    check("incr_cycles", 64'(ncyc), 64'd4);
    check("incr_arready_back", 64'(arready), 64'd1);
    check("incr_rvalid_drop", 64'(rvalid), 64'd0);

    // WRAP len=3 from 0x8: words 2,3,0,1
    issue_ar(32'h8, 8'd3, 3'd2, 2'b10, 12'h011);
    collect(3, 0);
    ed[0] = 32'h2222; ed[1] = 32'h3333; ed[2] = 32'h0000; ed[3] = 32'h1111;
    check_beats("wrap", 3, 12'h011, 1'b1);

    // FIXED len=2 at 0x4: word 1 three times
    issue_ar(32'h4, 8'd2, 3'd2, 2'b00, 12'h022);
    collect(2, 0);
    for (int i = 0; i < 3; i++) ed[i] = 32'h1111;
    check_beats("fixed", 2, 12'h022, 1'b1);

    // INCR len=7 with rready 1,0,0,1,0,0,...
    issue_ar(32'h0, 8'd7, 3'd2, 2'b01, 12'h033);
    collect(7, 1);
    for (int i = 0; i < 8; i++) ed[i] = DW'(i) * 32'h1111;
    check_beats("stall", 7, 12'h033, 1'b1);
    check("stall_cycles", 64'(ncyc), 64'd22);

    // size wider than the bus: SLVERR with zero data
    issue_ar(32'h0, 8'd1, 3'd3, 2'b01, 12'h044);
    collect(1, 0);
    for (int i = 0; i < 2; i++) begin ed[i] = 32'h0; er[i] = 2'b10; end
    check_beats("size", 1, 12'h044, 1'b1);

    // Reserved burst type: SLVERR on every beat
    issue_ar(32'h4, 8'd2, 3'd2, 2'b11, 12'h055);
    collect(2, 0);
    for (int i = 0; i < 3; i++) er[i] = 2'b10;
    check_beats("rsvd", 2, 12'h055, 1'b0);

    // Reset during beat 2 of a len=7 burst
    issue_ar(32'h0, 8'd7, 3'd2, 2'b01, 12'h066);
    rready = 1'b1;
    tick();
    check("midrst_beat2", 64'(rdata), 64'h1111);
    rst = 1'b1;
    tick();
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    rst = 1'b0;
    tick();
    check("midrst_arready", 64'(arready), 64'd1);
    check("midrst_no_beats", 64'(rvalid), 64'd0);
    rready = 1'b0;
    issue_ar(32'h10, 8'd1, 3'd2, 2'b01, 12'h077);
    collect(1, 0);
    ed[0] = 32'h4444; ed[1] = 32'h5555; er[0] = 2'b00; er[1] = 2'b00;
    check_beats("postrst", 1, 12'h077, 1'b1);

    // INCR len=3 from word 14 runs past the end of the 16-word memory
    issue_ar(32'h38, 8'd3, 3'd2, 2'b01, 12'h0C3);
    collect(3, 0);
    ed[0] = 32'hEEEE; ed[1] = 32'hFFFF; er[0] = 2'b00; er[1] = 2'b00;
`ifdef AXI4_SLV_RANGE_CHK_EN
    ed[2] = 32'h0; ed[3] = 32'h0; er[2] = 2'b10; er[3] = 2'b10;
`else
    ed[2] = 32'h0; ed[3] = 32'h1111; er[2] = 2'b00; er[3] = 2'b00;
`endif
    check_beats("range", 3, 12'h0C3, 1'b1);

    // Backdoor write to the word loaded on the same edge returns the old data
    wr_en   = 1'b1;
    wr_addr = 4'd6;
    wr_data = 32'hDEAD_BEEF;
    issue_ar(32'h18, 8'd0, 3'd2, 2'b01, 12'h0AA);
    collect(0, 0);
    ed[0] = 32'h6666; er[0] = 2'b00;
    check_beats("rbw_old", 0, 12'h0AA, 1'b1);
    issue_ar(32'h18, 8'd0, 3'd2, 2'b01, 12'h0AB);
    collect(0, 0);
    ed[0] = 32'hDEAD_BEEF;
    check_beats("rbw_new", 0, 12'h0AB, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
